// File: rtl/ccu_pkg.sv
// ccu_pkg: shared snoop channel types, FSM states and response bit positions for the CCU.
package ccu_pkg;
    localparam int unsigned CrRespDataTransfer = 0;
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  snoop;
        logic [2:0]  prot;
    } ac_chan_t;
    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } cd_chan_t;
    typedef struct packed {
        ac_chan_t ac;
        logic     ac_valid;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;
    typedef struct packed {
        logic       ac_ready;
        logic       cr_valid;
        logic [4:0] cr_resp;
        logic       cd_valid;
        cd_chan_t   cd;
    } snoop_resp_t;
    typedef enum logic [1:0] {IDLE, AC, RESP} snoop_state_e;
endpackage

// File: rtl/ccu_snoop_arbiter_if.sv
// ccu_snoop_arbiter_if: requester-side and master-side snoop buses of the snoop arbiter.
interface ccu_snoop_arbiter_if import ccu_pkg::*; #(parameter int unsigned NoReqs = 2) ();
    snoop_req_t  [NoReqs-1:0] slv_req;
    snoop_resp_t [NoReqs-1:0] slv_resp;
    snoop_req_t               mst_req;
    snoop_resp_t              mst_resp;
    modport slave  (input slv_req, mst_resp, output slv_resp, mst_req);
    modport master (output slv_req, mst_resp, input slv_resp, mst_req);
endinterface

// File: rtl/ccu_snoop_rr_arb.sv
// ccu_snoop_rr_arb: combinational round-robin pick of the first valid index at or after rr_i.
module ccu_snoop_rr_arb #(
    parameter  int unsigned NoReqs = 2,
    localparam int unsigned IdxW   = NoReqs > 1 ? $clog2(NoReqs) : 1
) (
    input  logic [NoReqs-1:0] valid_i,
    input  logic [IdxW-1:0]   rr_i,
    output logic [IdxW-1:0]   gnt_idx_o,
    output logic              gnt_valid_o
);
    int              s;
    logic [IdxW-1:0] idx;
    // Scan offsets from the far end so the nearest valid index to rr_i wins.
    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        s           = 0;
        idx         = '0;
        for (int i = NoReqs - 1; i >= 0; i--) begin
            s   = int'(rr_i) + i;
            s   = s >= int'(NoReqs) ? s - int'(NoReqs) : s;
            idx = IdxW'(s);
            if (valid_i[idx]) begin
                gnt_idx_o   = idx;
                gnt_valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ccu_snoop_arbiter.sv
// ccu_snoop_arbiter: shares one snoop master port between requesters, one locked transaction at a time.
module ccu_snoop_arbiter import ccu_pkg::*; #(
    parameter  int unsigned NoReqs = 2,
    localparam int unsigned IdxW   = NoReqs > 1 ? $clog2(NoReqs) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ccu_snoop_arbiter_if.slave  bus,
    output logic                busy_o
);
    snoop_state_e             state_q, state_d;
    logic [IdxW-1:0]          rr_q, rr_d, owner_q, owner_d, gnt_idx;
    logic                     cr_done_q, cr_done_d, cd_done_q, cd_done_d, dt_q, dt_d;
    logic                     gnt_valid, ac_hs, cr_hs, cd_hs, cd_block;
    logic [NoReqs-1:0]        ac_valids;
    snoop_req_t               own_req, mst_req;
    snoop_resp_t [NoReqs-1:0] slv_resp;

    assign own_req      = bus.slv_req[owner_q];
    assign bus.mst_req  = mst_req;
    assign bus.slv_resp = slv_resp;

    always_comb begin
        ac_valids = '0;
        for (int k = 0; k < int'(NoReqs); k++) ac_valids[k] = bus.slv_req[k].ac_valid;
    end

    ccu_snoop_rr_arb #(.NoReqs(NoReqs)) u_rr_arb (
        .valid_i     (ac_valids),
        .rr_i        (rr_q),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            owner_q   <= '0;
            cr_done_q <= 1'b0;
            cd_done_q <= 1'b0;
            dt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            cr_done_q <= cr_done_d;
            cd_done_q <= cd_done_d;
            dt_q      <= dt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        cr_done_d = cr_done_q;
        cd_done_d = cd_done_q;
        dt_d      = dt_q;
        case (state_q)
            IDLE: if (gnt_valid) begin
                owner_d = gnt_idx;
                state_d = AC;
            end
            AC: if (ac_hs) begin
                rr_d      = owner_q == IdxW'(NoReqs - 1) ? '0 : owner_q + 1'b1;
                cr_done_d = 1'b0;
                cd_done_d = 1'b0;
                dt_d      = 1'b0;
                state_d   = RESP;
            end
            RESP: begin
                if (cr_hs) begin
                    cr_done_d = 1'b1;
                    dt_d      = bus.mst_resp.cr_resp[CrRespDataTransfer];
                end
                if (cd_hs && bus.mst_resp.cd.last) cd_done_d = 1'b1;
                if (cr_done_d && (!dt_d || cd_done_d)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // CD is refused once CR has announced no data, including in the CR cycle itself.
    always_comb begin
        mst_req          = '0;
        slv_resp         = '0;
        cr_hs            = state_q == RESP && bus.mst_resp.cr_valid && own_req.cr_ready;
        cd_block         = cr_done_q ? !dt_q : cr_hs && !bus.mst_resp.cr_resp[CrRespDataTransfer];
        mst_req.ac       = state_q == AC ? own_req.ac : '0;
        mst_req.ac_valid = state_q == AC && own_req.ac_valid;
        mst_req.cr_ready = state_q == RESP && own_req.cr_ready;
        mst_req.cd_ready = state_q == RESP && own_req.cd_ready && !cd_block;
        ac_hs            = mst_req.ac_valid && bus.mst_resp.ac_ready;
        cd_hs            = mst_req.cd_ready && bus.mst_resp.cd_valid;
        slv_resp[owner_q].ac_ready = state_q == AC && bus.mst_resp.ac_ready;
        slv_resp[owner_q].cr_valid = state_q == RESP && bus.mst_resp.cr_valid;
        slv_resp[owner_q].cr_resp  = state_q == RESP ? bus.mst_resp.cr_resp : '0;
        slv_resp[owner_q].cd_valid = state_q == RESP && bus.mst_resp.cd_valid && !cd_block;
        slv_resp[owner_q].cd       = state_q == RESP ? bus.mst_resp.cd : '0;
        busy_o           = state_q != IDLE;
    end

`ifndef SYNTHESIS
    cd_after_nodata: assert property (@(posedge clk_i) disable iff (rst_i)
        !(state_q == RESP && bus.mst_resp.cd_valid && cd_block));
`endif
endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// tb_ccu_snoop_arbiter: directed checks of grant order, routing, data beats, backpressure and reset.
module tb_ccu_snoop_arbiter;
    import ccu_pkg::*;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_chk = 0;
    int   n_err = 0;

    ccu_snoop_arbiter_if #(.NoReqs(2)) bus ();

    ccu_snoop_arbiter #(.NoReqs(2)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester o must be the next grant; ac_valid shows up one cycle after the IDLE request.
    task automatic grant(input int o, input logic [31:0] addr);
        #1 chk("gnt_lat", bus.mst_req.ac_valid, 0);
        tick();
        chk("ac_valid", bus.mst_req.ac_valid, 1);
        chk("ac_addr", bus.mst_req.ac.addr, addr);
        chk("busy_ac", busy, 1);
        bus.mst_resp.ac_ready = 1'b1;
        #1;
        chk("ac_ready_own", bus.slv_resp[o].ac_ready, 1);
        chk("ac_ready_oth", bus.slv_resp[1-o].ac_ready, 0);
        tick();
        bus.slv_req[o].ac_valid = 1'b0;
        bus.mst_resp.ac_ready   = 1'b0;
    endtask

    task automatic cr(input int o, input logic dt);
        bus.mst_resp.cr_valid   = 1'b1;
        bus.mst_resp.cr_resp    = {4'b0, dt};
        bus.slv_req[o].cr_ready = 1'b1;
        #1;
        chk("cr_valid_own", bus.slv_resp[o].cr_valid, 1);
        chk("cr_resp_own", bus.slv_resp[o].cr_resp, {4'b0, dt});
        chk("cr_valid_oth", bus.slv_resp[1-o].cr_valid, 0);
        chk("mst_cr_ready", bus.mst_req.cr_ready, 1);
        tick();
        bus.mst_resp.cr_valid   = 1'b0;
        bus.mst_resp.cr_resp    = '0;
        bus.slv_req[o].cr_ready = 1'b0;
    endtask

    task automatic beats(input int o, input logic [63:0] base);
        bus.slv_req[o].cd_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bus.mst_resp.cd_valid   = 1'b1;
            bus.mst_resp.cd.data    = base + 64'(b);
            bus.mst_resp.cd.last    = b == 3;
            #1;
            chk("cd_valid_own", bus.slv_resp[o].cd_valid, 1);
            chk("cd_data_own", bus.slv_resp[o].cd.data, base + 64'(b));
            chk("cd_valid_oth", bus.slv_resp[1-o].cd_valid, 0);
            chk("mst_cd_ready", bus.mst_req.cd_ready, 1);
            chk("busy_cd", busy, 1);
            tick();
        end
        bus.mst_resp.cd_valid   = 1'b0;
        bus.mst_resp.cd         = '0;
        bus.slv_req[o].cd_ready = 1'b0;
    endtask

    task automatic set_req(input int o, input logic [31:0] addr);
        bus.slv_req[o].ac.addr  = addr;
        bus.slv_req[o].ac_valid = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.slv_req  = '0;
        bus.mst_resp = '0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_mst_req", bus.mst_req, 0);
        chk("rst_ac_ready0", bus.slv_resp[0].ac_ready, 0);
        chk("rst_cr_valid1", bus.slv_resp[1].cr_valid, 0);
        rst = 1'b0;
        tick();

        // single requester, no data
        set_req(0, 32'h100);
        grant(0, 32'h100);
        chk("t1_cr_valid1_pre", bus.slv_resp[1].cr_valid, 0);
        cr(0, 1'b0);
        chk("t1_busy_fall", busy, 0);

        // simultaneous pair from reset: 0, 1, then 0 again
        do_reset();
        set_req(0, 32'h200);
        set_req(1, 32'h300);
        grant(0, 32'h200);
        cr(0, 1'b0);
        grant(1, 32'h300);
        cr(1, 1'b0);
        set_req(0, 32'h210);
        set_req(1, 32'h310);
        grant(0, 32'h210);
        cr(0, 1'b0);
        grant(1, 32'h310);
        cr(1, 1'b0);

        // data snoop to requester 1: CR then 4 beats
        set_req(1, 32'h400);
        grant(1, 32'h400);
        cr(1, 1'b1);
        chk("t3_busy_after_cr", busy, 1);
        beats(1, 64'hA0);
        chk("t3_busy_end", busy, 0);

        // CD before CR
        set_req(0, 32'h500);
        grant(0, 32'h500);
        beats(0, 64'hB0);
        chk("t4_busy_wait_cr", busy, 1);
        cr(0, 1'b1);
        chk("t4_busy_end", busy, 0);

        // CR backpressure with the other requester waiting
        set_req(0, 32'h600);
        grant(0, 32'h600);
        set_req(1, 32'h700);
        bus.mst_resp.cr_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_cr_ready", bus.mst_req.cr_ready, 0);
            chk("bp_busy", busy, 1);
            chk("bp_ac_valid", bus.mst_req.ac_valid, 0);
            chk("bp_cr_valid_own", bus.slv_resp[0].cr_valid, 1);
            tick();
        end
        bus.slv_req[0].cr_ready = 1'b1;
        #1 chk("bp_cr_ready_go", bus.mst_req.cr_ready, 1);
        tick();
        bus.mst_resp.cr_valid   = 1'b0;
        bus.slv_req[0].cr_ready = 1'b0;
        chk("bp_busy_end", busy, 0);
        grant(1, 32'h700);
        cr(1, 1'b0);

        // asynchronous reset in RESP, then arbitration restarts at requester 0
        set_req(0, 32'h800);
        grant(0, 32'h800);
        bus.mst_resp.cr_valid   = 1'b1;
        bus.slv_req[0].cr_ready = 1'b1;
        #1 chk("ar_cr_valid_pre", bus.slv_resp[0].cr_valid, 1);
        rst = 1'b1;
        #1;
        chk("ar_cr_valid", bus.slv_resp[0].cr_valid, 0);
        chk("ar_cr_ready", bus.mst_req.cr_ready, 0);
        chk("ar_busy", busy, 0);
        bus.mst_resp.cr_valid   = 1'b0;
        bus.slv_req[0].cr_ready = 1'b0;
        tick();
        rst = 1'b0;
        set_req(0, 32'h900);
        set_req(1, 32'hA00);
        grant(0, 32'h900);
        cr(0, 1'b0);
        grant(1, 32'hA00);
        cr(1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
